// File: rtl/tc_pl_acp_pack_if.sv
// -----------------------------------------------------------------------------
// tc_pl_acp_pack_if
// Bundles the two streaming sides of the ACP frame packer:
//   merge_data / merge_datv / merge_datr : merged-record stream (valid/ready)
//   acp0_tx_en / acp0_tx_rdy             : burst request handshake
//   acp0_tx_awaddr / acp0_tx_awid        : burst start address and ID
//   acp0_tx_wdata / acp0_tx_wdreq        : write beats pulled by the engine
// Modports:
//   master : the packer (sinks records, issues bursts, supplies beats)
//   slave  : its surroundings (record source plus ACP transmit engine)
// -----------------------------------------------------------------------------
interface tc_pl_acp_pack_if #(
   parameter int DATA_W = 56
);
   logic [DATA_W-1:0] merge_data;
   logic              merge_datv;
   logic              merge_datr;
   logic              acp0_tx_en;
   logic              acp0_tx_rdy;
   logic [31:0]       acp0_tx_awaddr;
   logic [2:0]        acp0_tx_awid;
   logic [63:0]       acp0_tx_wdata;
   logic              acp0_tx_wdreq;

   modport master (
      input  merge_data, merge_datv, acp0_tx_rdy, acp0_tx_wdreq,
      output merge_datr, acp0_tx_en, acp0_tx_awaddr, acp0_tx_awid, acp0_tx_wdata
   );

   modport slave (
      output merge_data, merge_datv, acp0_tx_rdy, acp0_tx_wdreq,
      input  merge_datr, acp0_tx_en, acp0_tx_awaddr, acp0_tx_awid, acp0_tx_wdata
   );
endinterface

// File: rtl/tc_pl_acp_pack.sv
// -----------------------------------------------------------------------------
// tc_pl_acp_pack
// Buffers 56-bit merged records in a show-ahead FIFO, tags each with an 8-bit
// sequence number to form a 64-bit beat, and writes them to a PS frame buffer
// as fixed-length ACP bursts. A pulse is raised when a whole frame is written.
// Ports:
//   clk125, rst        : clock, asynchronous active-low reset
//   bus (master)       : record stream in, ACP burst/beat interface out
//   cfg_en             : packing enable (current burst always completes)
//   cfg_base           : frame buffer base byte address, sampled at frame start
//   cfg_bursts         : bursts per frame (0 behaves as 1), sampled at frame start
//   irq_frame          : one-cycle pulse while the last burst of a frame retires
//   frame_cnt          : completed frames, wrapping
//   err_flag           : sticky, beat request seen outside the DATA state
//   busy               : FSM is not IDLE
// -----------------------------------------------------------------------------
module tc_pl_acp_pack #(
   parameter int DATA_W    = 56,
   parameter int BURST_LEN = 16,
   parameter int FIFO_AW   = 5,
   parameter int CNT_W     = 16
) (
   input  logic                 clk125,
   input  logic                 rst,
   tc_pl_acp_pack_if.master     bus,
   input  logic                 cfg_en,
   input  logic [31:0]          cfg_base,
   input  logic [CNT_W-1:0]     cfg_bursts,
   output logic                 irq_frame,
   output logic [CNT_W-1:0]     frame_cnt,
   output logic                 err_flag,
   output logic                 busy
);

   localparam int DEPTH  = 1 << FIFO_AW;
   localparam int WORD_W = 8 + DATA_W;
   localparam int BEAT_W = $clog2(BURST_LEN) + 1;

   localparam logic [FIFO_AW:0]   FULL_CNT   = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0]   LVL_CNT    = (FIFO_AW+1)'(BURST_LEN);
   localparam logic [FIFO_AW:0]   ZERO_FCNT  = {(FIFO_AW+1){1'b0}};
   localparam logic [FIFO_AW:0]   ONE_FCNT   = {{FIFO_AW{1'b0}}, 1'b1};
   localparam logic [FIFO_AW-1:0] ONE_PTR    = {{(FIFO_AW-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   ZERO_CNT   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   ONE_CNT    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [BEAT_W-1:0]  ZERO_BEAT  = {BEAT_W{1'b0}};
   localparam logic [BEAT_W-1:0]  ONE_BEAT   = {{(BEAT_W-1){1'b0}}, 1'b1};
   localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
   localparam logic [31:0]        BURST_BYTES = 32'(BURST_LEN * 8);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_NEXT = 2'd3
   } state_t;

   // FIFO storage and pointers
   logic [WORD_W-1:0]  mem_r [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_r;
   logic [FIFO_AW-1:0] rd_ptr_r;
   logic [FIFO_AW:0]   count_r;
   logic [7:0]         seq_r;
   logic               full_s;
   logic               push_s;
   logic               pop_s;

   // Burst/frame control
   state_t             state_r;
   logic [31:0]        base_r;
   logic [31:0]        addr_r;
   logic [CNT_W-1:0]   remaining_r;
   logic [CNT_W-1:0]   bidx_r;
   logic [BEAT_W-1:0]  beat_cnt_r;
   logic [31:0]        awaddr_r;
   logic [2:0]         awid_r;
   logic               irq_r;
   logic [CNT_W-1:0]   frame_cnt_r;
   logic               err_r;
   logic               busy_r;

   // Handshake decode and show-ahead head; ready is held low during reset
   always_comb begin
      full_s             = (count_r == FULL_CNT);
      bus.merge_datr     = rst & ~full_s;
      push_s             = bus.merge_datv & bus.merge_datr;
      pop_s              = bus.acp0_tx_wdreq & (state_r == ST_DATA) & (count_r != ZERO_FCNT);
      bus.acp0_tx_en     = (state_r == ST_ADDR) & bus.acp0_tx_rdy;
      bus.acp0_tx_awaddr = awaddr_r;
      bus.acp0_tx_awid   = awid_r;
      if (count_r != ZERO_FCNT) begin
         bus.acp0_tx_wdata = mem_r[rd_ptr_r];
      end else begin
         bus.acp0_tx_wdata = 64'h0;
      end
      irq_frame = irq_r;
      frame_cnt = frame_cnt_r;
      err_flag  = err_r;
      busy      = busy_r;
   end

   // FIFO storage write: record tagged with its sequence number
   always_ff @(posedge clk125) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {seq_r, bus.merge_data};
      end
   end

   // FIFO pointers, occupancy and sequence counter
   always_ff @(posedge clk125 or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {FIFO_AW{1'b0}};
         rd_ptr_r <= {FIFO_AW{1'b0}};
         count_r  <= ZERO_FCNT;
         seq_r    <= 8'h00;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + ONE_PTR;
            seq_r    <= seq_r + 8'h01;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + ONE_PTR;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + ONE_FCNT;
            2'b01:   count_r <= count_r - ONE_FCNT;
            default: count_r <= count_r;
         endcase
      end
   end

   // Burst FSM: waits for a full burst in the FIFO, requests, streams, advances
   always_ff @(posedge clk125 or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         base_r      <= 32'h0;
         addr_r      <= 32'h0;
         remaining_r <= ZERO_CNT;
         bidx_r      <= ZERO_CNT;
         beat_cnt_r  <= ZERO_BEAT;
         awaddr_r    <= 32'h0;
         awid_r      <= 3'b000;
         irq_r       <= 1'b0;
         frame_cnt_r <= ZERO_CNT;
         err_r       <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         irq_r <= 1'b0;
         if (bus.acp0_tx_wdreq && (state_r != ST_DATA)) begin
            err_r <= 1'b1;
         end
         case (state_r)
            ST_IDLE: begin
               if (cfg_en && (count_r >= LVL_CNT)) begin
                  state_r <= ST_ADDR;
                  busy_r  <= 1'b1;
                  // remaining==0 marks a frame boundary: take fresh configuration
                  if (remaining_r == ZERO_CNT) begin
                     base_r      <= cfg_base;
                     addr_r      <= cfg_base;
                     remaining_r <= (cfg_bursts == ZERO_CNT) ? ONE_CNT : cfg_bursts;
                     bidx_r      <= ZERO_CNT;
                     awaddr_r    <= cfg_base;
                     awid_r      <= 3'b000;
                  end else begin
                     awaddr_r <= addr_r;
                     awid_r   <= bidx_r[2:0];
                  end
               end
            end
            ST_ADDR: begin
               if (bus.acp0_tx_rdy) begin
                  state_r    <= ST_DATA;
                  beat_cnt_r <= ZERO_BEAT;
               end
            end
            ST_DATA: begin
               if (pop_s) begin
                  if (beat_cnt_r == LAST_BEAT) begin
                     state_r    <= ST_NEXT;
                     beat_cnt_r <= ZERO_BEAT;
                     // pulse lands in the NEXT cycle of the frame's last burst
                     irq_r      <= (remaining_r == ONE_CNT);
                  end else begin
                     beat_cnt_r <= beat_cnt_r + ONE_BEAT;
                  end
               end
            end
            ST_NEXT: begin
               state_r     <= ST_IDLE;
               busy_r      <= 1'b0;
               remaining_r <= remaining_r - ONE_CNT;
               bidx_r      <= bidx_r + ONE_CNT;
               if (remaining_r == ONE_CNT) begin
                  frame_cnt_r <= frame_cnt_r + ONE_CNT;
                  addr_r      <= base_r;
               end else begin
                  addr_r <= addr_r + BURST_BYTES;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule
